pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB).
- Drives the write-enable and flush inputs of every inter-stage register, including the ID/EXE register's i_ena.
- Sequences multi-cycle mult/div residency in EXE, load-use bubbles, data-memory wait states, and exception/eret redirects.
- Sits beside the datapath: pure control, with no datapath values passing through it.

Parameters:
- MULT_CYCLES, 3, total cycles a mult instruction occupies EXE (legal range 2..15).
- DIV_CYCLES, 8, total cycles a div instruction occupies EXE (legal range 2..15).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
i_ID_uses_rs  in  1  ID instruction reads rs
i_ID_uses_rt  in  1  ID instruction reads rt
i_ID_rs  in  5  ID rs address
i_ID_rt  in  5  ID rt address
i_EXE_GPR_waddr  in  5  EXE destination GPR
i_EXE_GPR_we  in  1  EXE writes a GPR
i_EXE_get_result_in_MEM  in  1  EXE result ready only in MEM (load)
i_EXE_is_muldiv  in  1  EXE holds mult/div
i_EXE_is_div  in  1  EXE mult/div is a div
i_dmem_stall  in  1  data memory not ready this cycle
i_MEM_except_valid  in  1  MEM stage raises exception
i_MEM_is_eret  in  1  MEM stage holds eret
o_pc_ena  out  1  PC register write enable
o_IF_ID_ena  out  1  IF/ID enable
o_ID_EXE_ena  out  1  ID/EXE enable
o_EXE_MEM_ena  out  1  EXE/MEM enable
o_MEM_WB_ena  out  1  MEM/WB enable
o_IF_ID_flush  out  1  load bubble into IF/ID
o_ID_EXE_flush  out  1  load bubble into ID/EXE
o_EXE_MEM_flush  out  1  load bubble into EXE/MEM
o_except_redirect  out  1  PC selects exception vector
o_eret_redirect  out  1  PC selects EPC
o_md_busy  out  1  mult/div occupying EXE
o_stall_cycles  out  32  stall-cycle count (see Optional Feature)

Behaviour:
- FSM states: RUN, MD_WAIT, FLUSH. Reset state is RUN; the 4-bit counter md_cnt resets to 0.
- Outputs are combinational from state and inputs. During reset, all enables=1 and all flush/redirect/busy outputs=0.
- Priority of conditions within one cycle: redirect > dmem stall > mult/div > load-use.
- Redirect:
  - Trigger: i_MEM_except_valid or i_MEM_is_eret, in RUN or MD_WAIT.
  - Outputs: o_except_redirect=i_MEM_except_valid; o_eret_redirect=i_MEM_is_eret & ~i_MEM_except_valid.
  - Pipeline action: o_pc_ena=1; IF_ID, ID_EXE and EXE_MEM flush=1 with their ena=1; o_MEM_WB_ena=1.
  - Next state: FLUSH. md_cnt is cleared, aborting any mult/div; i_dmem_stall is ignored that cycle.
- FLUSH (exactly 1 cycle):
  - i_MEM_except_valid and i_MEM_is_eret are ignored; MEM now holds a bubble.
  - All enables=1, no flushes, next state RUN.
  - i_dmem_stall is still honoured in FLUSH. It holds all five enables at 0, but the state still advances to RUN.
- Dmem stall (RUN or MD_WAIT, no redirect):
  - All five enables=0, no flushes.
  - FSM and md_cnt hold.
- Mult/div start (RUN, i_EXE_is_muldiv=1):
  - Cycle outputs: o_md_busy=1; o_pc_ena, o_IF_ID_ena and o_ID_EXE_ena=0; o_EXE_MEM_flush=1.
  - Load md_cnt = (i_EXE_is_div ? DIV_CYCLES : MULT_CYCLES) - 1; next state MD_WAIT.
- MD_WAIT:
  - While md_cnt>1, outputs match the start cycle and md_cnt decrements.
  - When md_cnt==1: o_md_busy=1, all enables=1, no flush, md_cnt->0, next state RUN.
  - Total EXE residency is exactly MULT_CYCLES or DIV_CYCLES cycles, and the instruction advances on the last edge.
- Load-use (RUN only, no higher condition):
  - Condition: i_EXE_get_result_in_MEM & i_EXE_GPR_we & i_EXE_GPR_waddr!=0, and ((i_ID_uses_rs & i_ID_rs==waddr) | (i_ID_uses_rt & i_ID_rt==waddr)).
  - Action: o_pc_ena=0, o_IF_ID_ena=0, o_ID_EXE_flush=1 (ID_EXE ena=1) for exactly one cycle.
- Otherwise: all enables=1, no flushes.
- Reset asserted mid-MD_WAIT: asynchronous return to RUN with md_cnt=0.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - o_stall_cycles is a 32-bit counter, reset 0.
  - Increments on each cycle where o_pc_ena==0 and no redirect is active.
  - Wraps 0xFFFFFFFF->0.
- Undefined: o_stall_cycles tied to 0 and no counter flops are inferred.

Test Plan:
- Div in EXE, DIV_CYCLES=8 -> o_md_busy high exactly 8 cycles; o_ID_EXE_ena low 7 cycles then high; o_EXE_MEM_flush high 7 cycles.
- Load to r5 in EXE, ID reads rt=r5 -> one-cycle o_pc_ena=0, o_ID_EXE_flush=1; same load with waddr=0 -> no stall.
- i_dmem_stall high 3 cycles during MD_WAIT at md_cnt=4 -> all enables 0, md_cnt held at 4; on release, residency extended by 3 cycles.
- i_MEM_except_valid at MD_WAIT md_cnt=5 -> o_except_redirect=1, three flushes, next cycle FLUSH, o_md_busy=0; an exception asserted in FLUSH is ignored.
- i_MEM_except_valid and i_MEM_is_eret simultaneous -> only o_except_redirect=1.
- STALL_PERF_CNT_EN: 8-cycle div plus 1 load-use -> o_stall_cycles=8; counter preset 0xFFFFFFFF plus a stall -> 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Control bundle between the MIPS datapath and the stall/flush scheduler.
// master: datapath side (drives hazard/status inputs, consumes enables/flushes).
// slave:  scheduler side.
interface pipeline_stall_ctrl_if;
    logic        i_ID_uses_rs;
    logic        i_ID_uses_rt;
    logic [4:0]  i_ID_rs;
    logic [4:0]  i_ID_rt;
    logic [4:0]  i_EXE_GPR_waddr;
    logic        i_EXE_GPR_we;
    logic        i_EXE_get_result_in_MEM;
    logic        i_EXE_is_muldiv;
    logic        i_EXE_is_div;
    logic        i_dmem_stall;
    logic        i_MEM_except_valid;
    logic        i_MEM_is_eret;
    logic        o_pc_ena;
    logic        o_IF_ID_ena;
    logic        o_ID_EXE_ena;
    logic        o_EXE_MEM_ena;
    logic        o_MEM_WB_ena;
    logic        o_IF_ID_flush;
    logic        o_ID_EXE_flush;
    logic        o_EXE_MEM_flush;
    logic        o_except_redirect;
    logic        o_eret_redirect;
    logic        o_md_busy;
    logic [31:0] o_stall_cycles;

    modport master (
        output i_ID_uses_rs, i_ID_uses_rt, i_ID_rs, i_ID_rt,
               i_EXE_GPR_waddr, i_EXE_GPR_we, i_EXE_get_result_in_MEM,
               i_EXE_is_muldiv, i_EXE_is_div, i_dmem_stall,
               i_MEM_except_valid, i_MEM_is_eret,
        input  o_pc_ena, o_IF_ID_ena, o_ID_EXE_ena, o_EXE_MEM_ena, o_MEM_WB_ena,
               o_IF_ID_flush, o_ID_EXE_flush, o_EXE_MEM_flush,
               o_except_redirect, o_eret_redirect, o_md_busy, o_stall_cycles
    );

    modport slave (
        input  i_ID_uses_rs, i_ID_uses_rt, i_ID_rs, i_ID_rt,
               i_EXE_GPR_waddr, i_EXE_GPR_we, i_EXE_get_result_in_MEM,
               i_EXE_is_muldiv, i_EXE_is_div, i_dmem_stall,
               i_MEM_except_valid, i_MEM_is_eret,
        output o_pc_ena, o_IF_ID_ena, o_ID_EXE_ena, o_EXE_MEM_ena, o_MEM_WB_ena,
               o_IF_ID_flush, o_ID_EXE_flush, o_EXE_MEM_flush,
               o_except_redirect, o_eret_redirect, o_md_busy, o_stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline.
// Priority per cycle: redirect > dmem stall > mult/div > load-use.
// Optional macro STALL_PERF_CNT_EN adds a 32-bit stall-cycle counter;
// without it o_stall_cycles is tied to zero.
module pipeline_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 3,
    parameter int unsigned DIV_CYCLES  = 8
) (
    input logic                  clk,
    input logic                  resetn,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {RUN, MD_WAIT, FLUSH} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   md_cnt, md_cnt_nxt;
    logic               rs_hit, rt_hit, load_use, redirect;
    logic               pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena;
    logic               if_id_flush, id_exe_flush, exe_mem_flush;
    logic               except_redirect, eret_redirect, md_busy;

    // Hazard detection: load in EXE feeding a register read in ID, and MEM redirects.
    always_comb begin
        rs_hit   = bus.i_ID_uses_rs && (bus.i_ID_rs == bus.i_EXE_GPR_waddr);
        rt_hit   = bus.i_ID_uses_rt && (bus.i_ID_rt == bus.i_EXE_GPR_waddr);
        load_use = bus.i_EXE_get_result_in_MEM && bus.i_EXE_GPR_we &&
                   (bus.i_EXE_GPR_waddr != 5'd0) && (rs_hit || rt_hit);
        redirect = (state != FLUSH) && (bus.i_MEM_except_valid || bus.i_MEM_is_eret);
    end

    // State and mult/div residency counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // Next state and pipeline control; held at the free-running pattern during reset.
    always_comb begin
        state_nxt       = state;
        md_cnt_nxt      = md_cnt;
        pc_ena          = 1'b1;
        if_id_ena       = 1'b1;
        id_exe_ena      = 1'b1;
        exe_mem_ena     = 1'b1;
        mem_wb_ena      = 1'b1;
        if_id_flush     = 1'b0;
        id_exe_flush    = 1'b0;
        exe_mem_flush   = 1'b0;
        except_redirect = 1'b0;
        eret_redirect   = 1'b0;
        md_busy         = 1'b0;
        if (resetn) begin
            case (state)
                FLUSH: begin
                    // MEM holds a bubble; only a memory wait can freeze this cycle
                    state_nxt = RUN;
                    if (bus.i_dmem_stall) begin
                        pc_ena      = 1'b0;
                        if_id_ena   = 1'b0;
                        id_exe_ena  = 1'b0;
                        exe_mem_ena = 1'b0;
                        mem_wb_ena  = 1'b0;
                    end
                end
                default: begin
                    if (redirect) begin
                        except_redirect = bus.i_MEM_except_valid;
                        eret_redirect   = bus.i_MEM_is_eret && !bus.i_MEM_except_valid;
                        if_id_flush     = 1'b1;
                        id_exe_flush    = 1'b1;
                        exe_mem_flush   = 1'b1;
                        md_cnt_nxt      = '0;
                        state_nxt       = FLUSH;
                    end else if (bus.i_dmem_stall) begin
                        pc_ena      = 1'b0;
                        if_id_ena   = 1'b0;
                        id_exe_ena  = 1'b0;
                        exe_mem_ena = 1'b0;
                        mem_wb_ena  = 1'b0;
                        md_busy     = (state == MD_WAIT);
                    end else if (state == MD_WAIT) begin
                        md_busy = 1'b1;
                        if (md_cnt > CNT_W'(1)) begin
                            pc_ena        = 1'b0;
                            if_id_ena     = 1'b0;
                            id_exe_ena    = 1'b0;
                            exe_mem_flush = 1'b1;
                            md_cnt_nxt    = md_cnt - CNT_W'(1);
                        end else begin
                            md_cnt_nxt = '0;
                            state_nxt  = RUN;
                        end
                    end else if (bus.i_EXE_is_muldiv) begin
                        md_busy       = 1'b1;
                        pc_ena        = 1'b0;
                        if_id_ena     = 1'b0;
                        id_exe_ena    = 1'b0;
                        exe_mem_flush = 1'b1;
                        md_cnt_nxt    = bus.i_EXE_is_div ? CNT_W'(DIV_CYCLES - 1)
                                                         : CNT_W'(MULT_CYCLES - 1);
                        state_nxt     = MD_WAIT;
                    end else if (load_use) begin
                        pc_ena       = 1'b0;
                        if_id_ena    = 1'b0;
                        id_exe_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.o_pc_ena          = pc_ena;
    assign bus.o_IF_ID_ena       = if_id_ena;
    assign bus.o_ID_EXE_ena      = id_exe_ena;
    assign bus.o_EXE_MEM_ena     = exe_mem_ena;
    assign bus.o_MEM_WB_ena      = mem_wb_ena;
    assign bus.o_IF_ID_flush     = if_id_flush;
    assign bus.o_ID_EXE_flush    = id_exe_flush;
    assign bus.o_EXE_MEM_flush   = exe_mem_flush;
    assign bus.o_except_redirect = except_redirect;
    assign bus.o_eret_redirect   = eret_redirect;
    assign bus.o_md_busy         = md_busy;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Count cycles with the PC frozen, excluding redirect cycles; wraps naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (!pc_ena && !(except_redirect || eret_redirect)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.o_stall_cycles = stall_cnt;
`else
    assign bus.o_stall_cycles = '0;
`endif
endmodule
